// File: rtl/byte_lane_serializer.sv
// byte_lane_serializer
//   Takes a byte-masked word and emits only its enabled bytes, one per cycle,
//   lowest lane first. Both sides use a val/rdy handshake.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   reset     asynchronous, active-high reset
//   in_val    input word valid
//   in_rdy    block accepts a word this cycle (combinational on out_rdy)
//   in_en     per-lane enable, bit i qualifies in_d[8*i+7:8*i]
//   in_d      input word
//   out_val   out_byte is valid
//   out_rdy   consumer takes out_byte this cycle
//   out_byte  current byte
//   out_lane  lane index of out_byte
//   out_last  out_byte is the last enabled byte of its word
module byte_lane_serializer #(
    parameter int unsigned NBYTES = 2,
    localparam int unsigned LW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [NBYTES-1:0]     in_en,
    input  logic [8*NBYTES-1:0]   in_d,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [7:0]            out_byte,
    output logic [LW-1:0]         out_lane,
    output logic                  out_last
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              state_q, state_d;
    logic [8*NBYTES-1:0] word_q, word_d;
    logic [NBYTES-1:0]   mask_q, mask_d;
    logic                out_val_q, out_last_q;
    logic [7:0]          out_byte_q, out_byte_d;
    logic [LW-1:0]       out_lane_q, out_lane_d;
    logic                accept;

    function automatic logic [LW-1:0] lowest_lane(input logic [NBYTES-1:0] m);
        lowest_lane = '0;
        for (int i = NBYTES - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = LW'(i);
        end
    endfunction

    function automatic logic single_bit(input logic [NBYTES-1:0] m);
        single_bit = (m != '0) && ((m & (m - NBYTES'(1))) == '0);
    endfunction

    // A new word may enter in the same cycle the previous word's last byte
    // leaves, which keeps back-to-back words bubble-free.
    assign in_rdy = !reset &&
                    ((state_q == StIdle) || (out_val_q && out_rdy && out_last_q));
    assign accept = in_val && in_rdy;

    always_comb begin
        word_d     = word_q;
        mask_d     = mask_q;
        out_byte_d = '0;
        if (state_q == StSend && out_rdy) begin
            mask_d = mask_q & ~(NBYTES'(1) << out_lane_q);
        end
        if (accept) begin
            word_d = in_d;
            mask_d = in_en;
        end
        out_lane_d = lowest_lane(mask_d);
        if (mask_d != '0) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (LW'(i) == out_lane_d) out_byte_d = word_d[8*i +: 8];
            end
        end
        // An all-zero mask (drained or accepted empty) means nothing to send.
        state_d = (mask_d != '0) ? StSend : StIdle;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            word_q     <= '0;
            mask_q     <= '0;
            out_val_q  <= 1'b0;
            out_byte_q <= '0;
            out_lane_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            out_val_q  <= (state_d == StSend);
            out_byte_q <= out_byte_d;
            out_lane_q <= out_lane_d;
            out_last_q <= single_bit(mask_d);
        end
    end

    assign out_val  = out_val_q;
    assign out_byte = out_byte_q;
    assign out_lane = out_lane_q;
    assign out_last = out_last_q;

endmodule

// File: tb/tb_byte_lane_serializer.sv
// Directed and random checks for byte_lane_serializer (NBYTES = 2).
module tb_byte_lane_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [1:0]  in_en = '0;
    logic [15:0] in_d = '0;
    logic        out_val;
    logic        out_rdy = 1'b0;
    logic [7:0]  out_byte;
    logic [0:0]  out_lane;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [1:0]  en;
        logic [15:0] d;
        logic        ordy;
        logic [11:0] exp;  // {in_rdy, out_val, out_byte, out_lane, out_last}
    } vec_t;

    byte_lane_serializer #(.NBYTES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_en    (in_en),
        .in_d     (in_d),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_byte (out_byte),
        .out_lane (out_lane),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ex(input logic r, input logic v, input logic [7:0] b,
                                       input logic l, input logic last);
        return {r, v, b, l, last};
    endfunction

    function automatic vec_t mk(input logic v, input logic [1:0] en, input logic [15:0] d,
                                input logic ordy, input logic [11:0] e);
        vec_t t;
        t.v = v; t.en = en; t.d = d; t.ordy = ordy; t.exp = e;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [1:0] en, input logic [15:0] d,
                         input logic ordy);
        in_val  = v;
        in_en   = en;
        in_d    = d;
        out_rdy = ordy;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        drive(1'b0, 2'b00, 16'h0000, 1'b0);
        #1 reset = 1'b1;
        #2;
        obs = {in_rdy, out_val, out_byte, out_lane, out_last};
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_async got %h exp %h", obs, 12'h000);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        obs = {in_rdy, out_val, out_byte, out_lane, out_last};
        checks++;
        if (obs !== ex(1, 0, 8'h00, 0, 0)) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", obs, ex(1, 0, 8'h00, 0, 0));
        end
    endtask

    task automatic test_two_lanes();
        vec_t t[4];
        logic [11:0] obs;
        t[0] = mk(1, 2'b11, 16'h0201, 1, ex(1, 0, 8'h00, 0, 0));
        t[1] = mk(0, 2'b00, 16'h0000, 1, ex(0, 1, 8'h01, 0, 0));
        t[2] = mk(0, 2'b00, 16'h0000, 1, ex(1, 1, 8'h02, 1, 1));
        t[3] = mk(0, 2'b00, 16'h0000, 1, ex(1, 0, 8'h00, 0, 0));
        for (int i = 0; i < 4; i++) begin
            drive(t[i].v, t[i].en, t[i].d, t[i].ordy);
            #1;
            obs = {in_rdy, out_val, out_byte, out_lane, out_last};
            checks++;
            if (obs !== t[i].exp) begin
                errors++;
                $display("FAIL two_lanes[%0d] got %h exp %h", i, obs, t[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single_lanes();
        vec_t t[4];
        logic [11:0] obs;
        t[0] = mk(1, 2'b10, 16'h89ab, 1, ex(1, 0, 8'h00, 0, 0));
        t[1] = mk(1, 2'b01, 16'hcdef, 1, ex(1, 1, 8'h89, 1, 1));
        t[2] = mk(0, 2'b00, 16'h0000, 1, ex(1, 1, 8'hef, 0, 1));
        t[3] = mk(0, 2'b00, 16'h0000, 1, ex(1, 0, 8'h00, 0, 0));
        for (int i = 0; i < 4; i++) begin
            drive(t[i].v, t[i].en, t[i].d, t[i].ordy);
            #1;
            obs = {in_rdy, out_val, out_byte, out_lane, out_last};
            checks++;
            if (obs !== t[i].exp) begin
                errors++;
                $display("FAIL single_lanes[%0d] got %h exp %h", i, obs, t[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_empty_mask();
        vec_t t[4];
        logic [11:0] obs;
        t[0] = mk(1, 2'b00, 16'hcdef, 1, ex(1, 0, 8'h00, 0, 0));
        t[1] = mk(0, 2'b00, 16'h0000, 1, ex(1, 0, 8'h00, 0, 0));
        t[2] = mk(0, 2'b00, 16'h0000, 1, ex(1, 0, 8'h00, 0, 0));
        t[3] = mk(0, 2'b00, 16'h0000, 1, ex(1, 0, 8'h00, 0, 0));
        for (int i = 0; i < 4; i++) begin
            drive(t[i].v, t[i].en, t[i].d, t[i].ordy);
            #1;
            obs = {in_rdy, out_val, out_byte, out_lane, out_last};
            checks++;
            if (obs !== t[i].exp) begin
                errors++;
                $display("FAIL empty_mask[%0d] got %h exp %h", i, obs, t[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Junk words offered while in_rdy=0 must be ignored.
    task automatic test_backpressure();
        vec_t t[7];
        logic [11:0] obs;
        t[0] = mk(1, 2'b11, 16'h4567, 0, ex(1, 0, 8'h00, 0, 0));
        t[1] = mk(1, 2'b01, 16'hffff, 0, ex(0, 1, 8'h67, 0, 0));
        t[2] = mk(1, 2'b10, 16'h1234, 0, ex(0, 1, 8'h67, 0, 0));
        t[3] = mk(1, 2'b01, 16'hffff, 0, ex(0, 1, 8'h67, 0, 0));
        t[4] = mk(0, 2'b00, 16'h0000, 1, ex(0, 1, 8'h67, 0, 0));
        t[5] = mk(0, 2'b00, 16'h0000, 1, ex(1, 1, 8'h45, 1, 1));
        t[6] = mk(0, 2'b00, 16'h0000, 1, ex(1, 0, 8'h00, 0, 0));
        for (int i = 0; i < 7; i++) begin
            drive(t[i].v, t[i].en, t[i].d, t[i].ordy);
            #1;
            obs = {in_rdy, out_val, out_byte, out_lane, out_last};
            checks++;
            if (obs !== t[i].exp) begin
                errors++;
                $display("FAIL backpressure[%0d] got %h exp %h", i, obs, t[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t t[5];
        logic [11:0] obs;
        t[0] = mk(1, 2'b11, 16'h4567, 1, ex(1, 0, 8'h00, 0, 0));
        t[1] = mk(1, 2'b01, 16'h89ab, 1, ex(0, 1, 8'h67, 0, 0));
        t[2] = mk(1, 2'b01, 16'h89ab, 1, ex(1, 1, 8'h45, 1, 1));
        t[3] = mk(0, 2'b00, 16'h0000, 1, ex(1, 1, 8'hab, 0, 1));
        t[4] = mk(0, 2'b00, 16'h0000, 1, ex(1, 0, 8'h00, 0, 0));
        for (int i = 0; i < 5; i++) begin
            drive(t[i].v, t[i].en, t[i].d, t[i].ordy);
            #1;
            obs = {in_rdy, out_val, out_byte, out_lane, out_last};
            checks++;
            if (obs !== t[i].exp) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %h exp %h", i, obs, t[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_word();
        logic [11:0] obs;
        drive(1, 2'b11, 16'hcdef, 1);
        @(posedge clk);
        #1;
        drive(0, 2'b00, 16'h0000, 1);
        #1;
        obs = {in_rdy, out_val, out_byte, out_lane, out_last};
        checks++;
        if (obs !== ex(0, 1, 8'hef, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_first got %h exp %h", obs, ex(0, 1, 8'hef, 0, 0));
        end
        @(posedge clk);
        #1;
        obs = {in_rdy, out_val, out_byte, out_lane, out_last};
        checks++;
        if (obs !== ex(1, 1, 8'hcd, 1, 1)) begin
            errors++;
            $display("FAIL rst_mid_second got %h exp %h", obs, ex(1, 1, 8'hcd, 1, 1));
        end
        #1 reset = 1'b1;
        #1;
        obs = {in_rdy, out_val, out_byte, out_lane, out_last};
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_async got %h exp %h", obs, 12'h000);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        obs = {in_rdy, out_val, out_byte, out_lane, out_last};
        checks++;
        if (obs !== ex(1, 0, 8'h00, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_release got %h exp %h", obs, ex(1, 0, 8'h00, 0, 0));
        end
        @(posedge clk);
        #1;
        obs = {in_rdy, out_val, out_byte, out_lane, out_last};
        checks++;
        if (obs !== ex(1, 0, 8'h00, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_dropped got %h exp %h", obs, ex(1, 0, 8'h00, 0, 0));
        end
    endtask

    task automatic test_random();
        logic [9:0]  q[$];  // {byte, lane, last}
        logic [9:0]  got;
        logic [1:0]  cur_en;
        logic [15:0] cur_d;
        int          n_acc;
        n_acc  = 0;
        cur_en = 2'($urandom_range(0, 3));
        cur_d  = 16'($urandom);
        for (int cyc = 0; cyc < 800 && (n_acc < 20 || q.size() > 0); cyc++) begin
            drive(n_acc < 20, cur_en, cur_d, 1'($urandom_range(0, 1)));
            #1;
            if (out_val && out_rdy) begin
                got = {out_byte, out_lane, out_last};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra got %h exp none", got);
                end else begin
                    if (got !== q[0]) begin
                        errors++;
                        $display("FAIL random_byte got %h exp %h", got, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (in_val && in_rdy) begin
                if (cur_en[0]) q.push_back({cur_d[7:0], 1'b0, !cur_en[1]});
                if (cur_en[1]) q.push_back({cur_d[15:8], 1'b1, 1'b1});
                n_acc++;
                cur_en = 2'($urandom_range(0, 3));
                cur_d  = 16'($urandom);
            end
            @(posedge clk);
            #1;
        end
        drive(0, 2'b00, 16'h0000, 1);
        checks++;
        if (n_acc != 20 || q.size() != 0) begin
            errors++;
            $display("FAIL random_done got words=%0d left=%0d exp words=20 left=0",
                     n_acc, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_two_lanes();
        test_single_lanes();
        test_empty_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_two_lanes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_lane_serializer.md
Name: byte_lane_serializer

Overview:
Reads a 16-bit word with per-byte lane enables and emits only the enabled bytes, one per cycle, lowest lane first. It uses a val/rdy handshake on both sides. It converts byte-masked register writes into a byte stream for narrow downstream consumers. Lane-enable semantics match the byte-enabled DFF blocks: en[i] qualifies d[8*i+7:8*i].

Parameters:
NBYTES, 2, number of byte lanes; word width is 8*NBYTES.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_val  input  1  input word valid.
in_rdy  output  1  block can accept a word this cycle.
in_en  input  NBYTES  per-lane enable; bit i qualifies byte i.
in_d  input  8*NBYTES  input word.
out_val  output  1  out_byte is valid.
out_rdy  input  1  consumer accepts out_byte this cycle.
out_byte  output  8  current byte.
out_lane  output  clog2(NBYTES) (1 for default)  lane index of out_byte.
out_last  output  1  out_byte is the final enabled byte of the word.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values: on assertion, with no clock edge needed:
  - state IDLE; held word = 0; held mask = 0.
  - out_val=0, out_byte=0x00, out_lane=0, out_last=0.
  - in_rdy=0 while reset is high; in_rdy=1 in the first cycle after deassertion.
- States: IDLE and SEND.
- Accept: an input transfer occurs on a rising edge when in_val && in_rdy.
  - Any in_d is allowed.
  - Accepted word goes to the held word register; in_en goes to the held mask.
- in_rdy:
  - 1 in IDLE.
  - In SEND, 1 only in the cycle where out_val && out_rdy && out_last (the final byte departs this edge).
  - Otherwise 0.
  - in_rdy may depend combinationally on out_rdy.
- IDLE transitions:
  - Accept with in_en != 0 → SEND.
  - Accept with in_en == 0 → word discarded, stay IDLE, nothing emitted.
  - No accept → stay IDLE.
- SEND outputs:
  - out_val=1.
  - out_lane = index of the lowest set bit of the held mask.
  - out_byte = held word byte at out_lane.
  - out_last = 1 iff the held mask has exactly one set bit.
- SEND on an edge with out_rdy=1:
  - Clear the mask bit at out_lane.
  - If out_last: accept a new word if one is offered. New mask != 0 → stay SEND; mask == 0 or no word → IDLE.
- SEND on an edge with out_rdy=0: hold everything.
  - out_val never retracts.
  - out_byte, out_lane and out_last stay stable until transferred.
- Latency: word accepted at edge N → first byte valid after edge N.
  - k enabled lanes take k transfer cycles.
  - Back-to-back words with out_rdy=1 produce no bubble between words.
- Out-of-handshake inputs: in_en and in_d are ignored whenever no input transfer occurs.
- Reset mid-word: remaining bytes are dropped; they are never emitted after reset.

Test Plan:
- Two lanes, no stall: after reset, in_rdy=1 and out_val=0. Apply en=11, d=0x0201 for one cycle, out_rdy=1.
  - Next cycle: out_byte=0x01, lane 0, last 0, in_rdy=0.
  - Following cycle: out_byte=0x02, lane 1, last 1, in_rdy=1.
  - Then out_val=0.
- Single lanes: en=10, d=0x89ab → one byte 0x89, lane 1, last 1. en=01, d=0xcdef → one byte 0xef, lane 0, last 1.
- Empty mask: en=00, d=0xcdef accepted → out_val stays 0 for 3 cycles, in_rdy stays 1.
- Backpressure: en=11, d=0x4567, out_rdy=0 for 3 cycles.
  - out_val=1 with out_byte=0x67, lane 0 stable throughout.
  - Then out_rdy=1 → 0x67, then 0x45 last.
- Back-to-back: offer 0x4567/en=11 then 0x89ab/en=01 continuously, out_rdy=1.
  - Bytes 0x67, 0x45, 0xab on consecutive cycles.
  - Second word accepted in the 0x45 cycle.
- Async reset mid-word: en=11, d=0xcdef; after 0xef transfers, pulse reset mid-cycle.
  - out_val=0 immediately and 0xcd is never emitted.
  - After release, in_rdy=1 and a new word 0x0201/en=11 yields 0x01, 0x02.
- Random: 20 random (en, d) words with random out_rdy. Emitted byte sequence must match the enabled bytes of each word in lane order, with out_last exactly on each word's final byte.
